stage_mem_row: RTL
==================

# stage_mem_row

Pipeline memory stage with a word-serial request/grant/response bus to data memory instead of an internal single-cycle RAM. It performs scalar loads and stores (byte, half and word, with sign or zero extension), plus matrix-row loads and stores of `LANES` consecutive words. It holds the pipeline with `me_stall` until each access completes, and it captures write-back forwarding data when it accepts an access. The block sits between the execute and write-back stages.

## Interface
- `LANES`, default 4: words per matrix row (power of two, 2..16).
- `ADDR_W`, default 32: bus address width.
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous, active-low reset.
- `me_valid` in 1: instruction valid in the MEM stage.
- `me_mem_read` / `me_mem_write` in 1 each: load or store request; never both set.
- `me_func3_code` in 3: LB/LH/LW/LBU/LHU, SB/SH/SW.
- `me_w_select` in 2: 2'b11 means a matrix-row access; any other value means scalar.
- `me_alu_o` in ADDR_W: byte address.
- `me_rs2` in 5: source register; for a scalar store, `me_rs2[$clog2(LANES)-1:0]` selects the lane of forwarded matrix data.
- `me_regs_data2` in 32: scalar store data.
- `me_matrix_data2` in 32*LANES: row store data; lane 0 is bits [31:0].
- `forward_data` in 1: forwarding enable.
- `wb_w_select` in 2: 2'b11 means the write-back value is a matrix row.
- `w_regs_data` in 32: forwarded scalar value.
- `w_matrix_data` in 32*LANES: forwarded matrix row.
- `mem_req` out 1: bus request.
- `mem_we` out 1: bus write.
- `mem_addr` out ADDR_W: word-aligned bus address.
- `mem_be` out 4: byte enables.
- `mem_wdata` out 32: bus write data.
- `mem_gnt` in 1: grant; a beat is accepted when `mem_req & mem_gnt`.
- `mem_rvalid` in 1: read data valid.
- `mem_rdata` in 32: read data.
- `me_stall` out 1: pipeline hold.
- `me_done` out 1: one-cycle pulse when an access completes.
- `me_misalign` out 1: asserted with `me_done` when the access faulted.
- `me_mem_data` out 32: scalar load result.
- `me_row_data` out 32*LANES: row load result.

## Operation
- States:
  - IDLE: no access in progress.
  - ISSUE: presenting a beat to the bus.
  - WAIT_R: waiting for read data.
  - RESP: completion cycle.
- IDLE, with `me_valid` and (`me_mem_read` or `me_mem_write`):
  - Register the address, func3, access kind and store data; clear the beat counter.
  - Go to ISSUE, or go directly to RESP with the fault flag set if the access is misaligned.
- Store data selection at accept, applied per lane:
  - `forward_data=1` and `wb_w_select=2'b11`: use `w_matrix_data`. A scalar store uses the lane selected by `me_rs2`; a row store uses all lanes.
  - `forward_data=1` and `wb_w_select` not 2'b11: a scalar store uses `w_regs_data`; a row store uses `me_matrix_data2`.
  - `forward_data=0`: use `me_regs_data2` (scalar) or `me_matrix_data2` (row).
- Misalignment rules:
  - LH, LHU and SH fault if `addr[0]=1`.
  - LW, SW and row accesses fault if `addr[1:0]` is nonzero.
  - A faulting access generates no bus traffic.
- ISSUE:
  - Outputs: `mem_req=1`, `mem_addr={addr[ADDR_W-1:2]+beat, 2'b00}`, `mem_we`=store.
  - Scalar store byte enables: SB drives `mem_be=4'b0001<<addr[1:0]` with the byte replicated on all four byte lanes. SH drives `4'b0011<<{addr[1],1'b0}` with the half replicated. SW drives 4'b1111.
  - Loads and row accesses drive `mem_be=4'b1111`.
  - On grant, a load goes to WAIT_R. A store increments the beat counter, or goes to RESP after the last beat.
- WAIT_R, on `mem_rvalid`:
  - Capture `mem_rdata` into the lane indexed by the beat counter (row access), or into the scalar buffer.
  - Go to ISSUE for the next beat, or to RESP after the last beat.
- `mem_rvalid` is ignored in every state other than WAIT_R.
- Scalar load extraction: shift the word right by `addr[1:0]*8`, then apply LB/LH sign extension or LBU/LHU zero extension.
- RESP: `me_done=1`, `me_stall=0`, then return to IDLE.
- `me_stall = me_valid & (me_mem_read | me_mem_write) & (state != RESP)`.
- Reset values: all outputs 0, state IDLE, beat counter 0, data registers 0.
  - Because reset is asynchronous, `mem_req` drops immediately when `rst` falls, including mid-transfer.
  - A response arriving after reset is discarded.

## Timing
- A beat requires at least 1 cycle in ISSUE, plus 1 cycle in WAIT_R for loads.
- Minimum scalar load: the accept cycle T, ISSUE at T+1 with `mem_gnt=1`, `mem_rvalid` at T+2, RESP at T+3. `me_stall` is high for T..T+2.
- Minimum scalar store: `me_done` at T+2.
- Minimum row load: `me_done` at T+2·LANES+1.
- Minimum row store: `me_done` at T+LANES+1.
- `mem_addr`, `mem_we`, `mem_be` and `mem_wdata` hold stable while `mem_req=1` and `mem_gnt=0`.
- A faulting access completes at T+1.
- `me_mem_data` and `me_row_data` are valid from RESP and hold until the next load's RESP.

## Configuration
- `MEM_ROW_XFER_EN` defined: row accesses work as described above.
- `MEM_ROW_XFER_EN` undefined:
  - Any access with `me_w_select=2'b11` takes the fault path (`me_misalign=1`, no bus traffic).
  - The beat counter and lane buffer logic are removed.
  - `me_row_data` is tied to 0.

## Test plan
- SW of 0xDEADBEEF to 0x100, then LW from 0x100, with `mem_gnt=1` and `mem_rvalid` one cycle after grant:
  - Store: `mem_be=4'hF`, `mem_wdata=0xDEADBEEF`.
  - Load: `me_mem_data=0xDEADBEEF` at T+3.
  - `me_stall` is high for exactly 3 cycles.
- LB from 0x103 where the word there is 0x80112233: `me_mem_data=0xFFFFFF80`. LBU from the same address gives 0x00000080. SH of 0x1234 to 0x102 drives `mem_be=4'b1100`, `mem_wdata=0x12341234`.
- Row store to 0x200 with `LANES=4`, `forward_data=1`, `wb_w_select=2'b11`, `w_matrix_data={4,3,2,1}`: four beats at 0x200, 0x204, 0x208 and 0x20C carrying data 1, 2, 3, 4. `me_done` fires at T+5.
- `mem_gnt` held low for 3 cycles during an LW: `mem_req` and all bus fields stay constant, and `me_done` is delayed by exactly 3 cycles.
- LW at 0x102: no `mem_req`, and `me_done=me_misalign=1` at T+1. The same fault response occurs for a row access when `MEM_ROW_XFER_EN` is undefined.
- `rst` asserted low during beat 2 of a row load: `mem_req=0` immediately and state returns to IDLE. A later `mem_rvalid` is ignored, and the next LW completes normally.

Source files
------------

// File: rtl/stage_mem_row.sv
// stage_mem_row: MEM stage that runs scalar and matrix-row accesses over a word-serial req/gnt/rvalid bus.
// Optional feature macro MEM_ROW_XFER_EN: multi-beat row transfers; when undefined, row accesses take the fault path.
module stage_mem_row #(
    parameter int LANES  = 4,
    parameter int ADDR_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  me_valid,
    input  logic                  me_mem_read,
    input  logic                  me_mem_write,
    input  logic [2:0]            me_func3_code,
    input  logic [1:0]            me_w_select,
    input  logic [ADDR_W-1:0]     me_alu_o,
    input  logic [4:0]            me_rs2,
    input  logic [31:0]           me_regs_data2,
    input  logic [32*LANES-1:0]   me_matrix_data2,
    input  logic                  forward_data,
    input  logic [1:0]            wb_w_select,
    input  logic [31:0]           w_regs_data,
    input  logic [32*LANES-1:0]   w_matrix_data,
    output logic                  mem_req,
    output logic                  mem_we,
    output logic [ADDR_W-1:0]     mem_addr,
    output logic [3:0]            mem_be,
    output logic [31:0]           mem_wdata,
    input  logic                  mem_gnt,
    input  logic                  mem_rvalid,
    input  logic [31:0]           mem_rdata,
    output logic                  me_stall,
    output logic                  me_done,
    output logic                  me_misalign,
    output logic [31:0]           me_mem_data,
    output logic [32*LANES-1:0]   me_row_data
);
    localparam int BW = $clog2(LANES);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT_R, RESP} state_t;

    state_t             state_q, state_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [2:0]         func3_q, func3_d;
    logic               is_st_q, is_st_d;
    logic               fault_q, fault_d;
    logic [31:0]        mem_data_q, mem_data_d;

    logic [LANES-1:0][31:0] w_mat;
    logic [31:0]        st_scalar, st_word, ld_shift, ld_word;
    logic               is_row_in, acc_in, mis_in, last_beat, row_cur;
    logic [ADDR_W-3:0]  beat_ext;
    logic               unused_in;

    assign w_mat     = w_matrix_data;
    assign is_row_in = (me_w_select == 2'b11);
    assign acc_in    = me_valid & (me_mem_read | me_mem_write);

`ifdef MEM_ROW_XFER_EN
    logic                   is_row_q, is_row_d;
    logic [BW-1:0]          beat_q, beat_d;
    logic [LANES-1:0][31:0] wdata_q, wdata_d, lbuf_q, lbuf_d, row_q, row_d, st_row;

    assign row_cur   = is_row_q;
    assign last_beat = !is_row_q || (beat_q == BW'(LANES - 1));
    assign beat_ext  = (ADDR_W-2)'(beat_q);
    assign st_word   = is_row_q ? wdata_q[beat_q] : wdata_q[0];
    assign me_row_data = row_q;
    assign unused_in = ^me_rs2[4:BW];
`else
    logic [31:0] wdata_q, wdata_d;

    assign row_cur   = 1'b0;
    assign last_beat = 1'b1;
    assign beat_ext  = '0;
    assign st_word   = wdata_q;
    assign me_row_data = '0;
    assign unused_in = ^{me_rs2[4:BW], me_matrix_data2};
`endif

    // Forwarded write-back data wins over the register-file operand.
    always_comb begin
        st_scalar = me_regs_data2;
        if (forward_data)
            st_scalar = (wb_w_select == 2'b11) ? w_mat[me_rs2[BW-1:0]] : w_regs_data;
`ifdef MEM_ROW_XFER_EN
        st_row = me_matrix_data2;
        if (forward_data && wb_w_select == 2'b11)
            st_row = w_mat;
`endif
    end

    always_comb begin
        case (me_func3_code[1:0])
            2'b01:   mis_in = me_alu_o[0];
            2'b10:   mis_in = |me_alu_o[1:0];
            default: mis_in = 1'b0;
        endcase
`ifdef MEM_ROW_XFER_EN
        if (is_row_in) mis_in = |me_alu_o[1:0];
`else
        if (is_row_in) mis_in = 1'b1;
`endif
    end

    assign ld_shift = mem_rdata >> {addr_q[1:0], 3'b000};

    always_comb begin
        case (func3_q)
            3'b000:  ld_word = {{24{ld_shift[7]}}, ld_shift[7:0]};
            3'b001:  ld_word = {{16{ld_shift[15]}}, ld_shift[15:0]};
            3'b100:  ld_word = {24'h0, ld_shift[7:0]};
            3'b101:  ld_word = {16'h0, ld_shift[15:0]};
            default: ld_word = ld_shift;
        endcase
    end

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        func3_d    = func3_q;
        is_st_d    = is_st_q;
        fault_d    = fault_q;
        mem_data_d = mem_data_q;
        wdata_d    = wdata_q;
`ifdef MEM_ROW_XFER_EN
        is_row_d   = is_row_q;
        beat_d     = beat_q;
        lbuf_d     = lbuf_q;
        row_d      = row_q;
`endif
        case (state_q)
            IDLE: if (acc_in) begin
                addr_d  = me_alu_o;
                func3_d = me_func3_code;
                is_st_d = me_mem_write;
                fault_d = mis_in;
                state_d = mis_in ? RESP : ISSUE;
`ifdef MEM_ROW_XFER_EN
                is_row_d = is_row_in;
                beat_d   = '0;
                wdata_d  = is_row_in ? st_row : {{(LANES-1)*32{1'b0}}, st_scalar};
`else
                wdata_d  = st_scalar;
`endif
            end
            ISSUE: if (mem_gnt) begin
                if (!is_st_q)
                    state_d = WAIT_R;
                else if (last_beat)
                    state_d = RESP;
`ifdef MEM_ROW_XFER_EN
                else
                    beat_d = beat_q + 1'b1;
`endif
            end
            WAIT_R: if (mem_rvalid) begin
`ifdef MEM_ROW_XFER_EN
                if (is_row_q) begin
                    lbuf_d[beat_q] = mem_rdata;
                    if (last_beat) row_d = lbuf_d;
                end else
                    mem_data_d = ld_word;
                if (!last_beat) begin
                    beat_d  = beat_q + 1'b1;
                    state_d = ISSUE;
                end else
                    state_d = RESP;
`else
                mem_data_d = ld_word;
                state_d    = RESP;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            func3_q    <= '0;
            is_st_q    <= 1'b0;
            fault_q    <= 1'b0;
            mem_data_q <= '0;
            wdata_q    <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            func3_q    <= func3_d;
            is_st_q    <= is_st_d;
            fault_q    <= fault_d;
            mem_data_q <= mem_data_d;
            wdata_q    <= wdata_d;
        end
    end

`ifdef MEM_ROW_XFER_EN
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            is_row_q <= 1'b0;
            beat_q   <= '0;
            lbuf_q   <= '0;
            row_q    <= '0;
        end else begin
            is_row_q <= is_row_d;
            beat_q   <= beat_d;
            lbuf_q   <= lbuf_d;
            row_q    <= row_d;
        end
    end
`endif

    // Bus fields are pure decodes of held registers, so they stay put while gnt is low.
    always_comb begin
        mem_req   = (state_q == ISSUE);
        mem_we    = mem_req & is_st_q;
        mem_addr  = '0;
        mem_be    = 4'h0;
        mem_wdata = 32'h0;
        if (mem_req) begin
            mem_addr = {addr_q[ADDR_W-1:2] + beat_ext, 2'b00};
            mem_be   = 4'hF;
            if (is_st_q) begin
                mem_wdata = st_word;
                if (!row_cur) begin
                    case (func3_q[1:0])
                        2'b00: begin
                            mem_be    = 4'b0001 << addr_q[1:0];
                            mem_wdata = {4{st_word[7:0]}};
                        end
                        2'b01: begin
                            mem_be    = 4'b0011 << {addr_q[1], 1'b0};
                            mem_wdata = {2{st_word[15:0]}};
                        end
                        default: ;
                    endcase
                end
            end
        end
    end

    assign me_stall    = acc_in & (state_q != RESP);
    assign me_done     = (state_q == RESP);
    assign me_misalign = (state_q == RESP) & fault_q;
    assign me_mem_data = mem_data_q;

endmodule
